// File: rtl/sb_pkg.sv
// sb_pkg: shared constants and the buffer entry type for the store buffer.
//   SB_DEPTH : number of posted-write entries (power of 2, >= 2)
//   SB_AW    : core word-address width
//   SB_DW    : data width
//   sb_entry_t : one buffered store {addr, data}
package sb_pkg;

    localparam int SB_DEPTH = 4;
    localparam int SB_AW    = 7;
    localparam int SB_DW    = 32;

    typedef struct packed {
        logic [SB_AW-1:0] addr;
        logic [SB_DW-1:0] data;
    } sb_entry_t;

endpackage

// File: rtl/sb_forward.sv
// sb_forward: combinational store-to-load forwarding lookup.
//   i_entries : buffer storage array
//   i_valid   : per-slot valid mask
//   i_tail    : tail pointer; slots are scanned oldest-to-youngest starting at tail
//   i_addr    : load word address
//   o_hit     : some valid entry matches i_addr
//   o_data    : data of the youngest matching entry (0 when no hit)
module sb_forward
    import sb_pkg::*;
#(
    parameter int DEPTH = SB_DEPTH,
    localparam int PW   = $clog2(DEPTH)
) (
    input  sb_entry_t         i_entries [DEPTH],
    input  logic [DEPTH-1:0]  i_valid,
    input  logic [PW-1:0]     i_tail,
    input  logic [SB_AW-1:0]  i_addr,
    output logic              o_hit,
    output logic [SB_DW-1:0]  o_data
);

    logic [PW-1:0] w_idx;

    // Slot tail+k has age k: tail itself is the oldest possible slot and
    // tail-1 the youngest. Scanning k upward lets later matches overwrite
    // earlier ones, so the youngest match wins.
    always_comb begin
        o_hit  = 1'b0;
        o_data = '0;
        w_idx  = '0;
        for (int k = 0; k < DEPTH; k++) begin
            w_idx = i_tail + PW'(k);
            if (i_valid[w_idx] && (i_entries[w_idx].addr == i_addr)) begin
                o_hit  = 1'b1;
                o_data = i_entries[w_idx].data;
            end
        end
    end

endmodule

// File: rtl/store_buffer.sv
// store_buffer: posted-write FIFO between the core data port and backing SRAM.
//   clk, rst_n          : clock, asynchronous active-low reset
//   CEN, WEN, OEN, A, D : core port (CEN low = access, WEN low = store, OEN low = drive Q)
//   Q                   : load data (forwarded from the buffer or taken from bk_rdata)
//   stall               : store presented while full; core holds PC and re-presents
//   bk_raddr, bk_rdata  : combinational backing read port
//   bk_wreq, bk_waddr, bk_wdata, bk_wack : backing write drain handshake
// AW and DW must match the package widths, since entries are stored as sb_entry_t.
module store_buffer
    import sb_pkg::*;
#(
    parameter int DEPTH = SB_DEPTH,
    parameter int AW    = SB_AW,
    parameter int DW    = SB_DW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          CEN,
    input  logic          WEN,
    input  logic          OEN,
    input  logic [AW-1:0] A,
    input  logic [DW-1:0] D,
    output logic [DW-1:0] Q,
    output logic          stall,
    output logic [AW-1:0] bk_raddr,
    input  logic [DW-1:0] bk_rdata,
    output logic          bk_wreq,
    output logic [AW-1:0] bk_waddr,
    output logic [DW-1:0] bk_wdata,
    input  logic          bk_wack
);

    localparam int            PW       = $clog2(DEPTH);
    localparam logic [PW:0]   FULL_CNT = (PW+1)'(DEPTH);

    sb_entry_t        r_entries [DEPTH];
    logic [PW-1:0]    r_head;
    logic [PW-1:0]    r_tail;
    logic [PW:0]      r_count;

    logic             w_store;
    logic             w_load;
    logic             w_full;
    logic             w_push;
    logic             w_pop;
    logic [DEPTH-1:0] w_valid;
    logic [PW-1:0]    w_off;
    logic             w_hit;
    logic [DW-1:0]    w_fwd_data;

    assign w_store = !CEN && !WEN;
    assign w_load  = !CEN &&  WEN && !OEN;
    assign w_full  = (r_count == FULL_CNT);

    // Stall depends on the current count only: a pop in the same cycle does
    // not make room for the store; the core re-presents it next cycle.
    assign stall   = w_store && w_full;
    assign w_push  = w_store && !w_full;

    // Drain handshake: bk_wreq is a valid that stays high with bk_waddr and
    // bk_wdata held stable until the posedge on which bk_wack is also high;
    // that edge is the transfer. bk_wack with bk_wreq low has no effect.
    assign bk_wreq  = (r_count != '0);
    assign w_pop    = bk_wreq && bk_wack;
    assign bk_waddr = r_entries[r_head].addr;
    assign bk_wdata = r_entries[r_head].data;
    assign bk_raddr = A;

    // A slot is live when its distance from head (mod DEPTH) is below count.
    always_comb begin
        w_valid = '0;
        w_off   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_off      = PW'(i) - r_head;
            w_valid[i] = ({1'b0, w_off} < r_count);
        end
    end

    sb_forward #(
        .DEPTH (DEPTH)
    ) u_forward (
        .i_entries (r_entries),
        .i_valid   (w_valid),
        .i_tail    (r_tail),
        .i_addr    (A),
        .o_hit     (w_hit),
        .o_data    (w_fwd_data)
    );

    assign Q = w_load ? (w_hit ? w_fwd_data : bk_rdata) : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_entries[i] <= '0;
            end
        end else begin
            if (w_push) begin
                r_entries[r_tail] <= sb_entry_t'{addr: A, data: D};
                r_tail            <= r_tail + 1'b1;
            end
            if (w_pop) begin
                r_head <= r_head + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: tb/tb_store_buffer.sv
// tb_store_buffer: directed + randomized bench for store_buffer with a
// queue-based reference model and a decoupled monitor/scoreboard.
module tb_store_buffer;
    import sb_pkg::*;

    localparam int DEPTH = SB_DEPTH;
    localparam int AW    = SB_AW;
    localparam int DW    = SB_DW;

    // ---------------- clock / reset ----------------
    logic          clk = 1'b0;
    logic          rst_n;
    logic          CEN, WEN, OEN;
    logic [AW-1:0] A;
    logic [DW-1:0] D;
    logic [DW-1:0] Q;
    logic          stall;
    logic [AW-1:0] bk_raddr;
    logic [DW-1:0] bk_rdata;
    logic          bk_wreq;
    logic [AW-1:0] bk_waddr;
    logic [DW-1:0] bk_wdata;
    logic          bk_wack;

    always #5 clk = ~clk;

    store_buffer #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .CEN      (CEN),
        .WEN      (WEN),
        .OEN      (OEN),
        .A        (A),
        .D        (D),
        .Q        (Q),
        .stall    (stall),
        .bk_raddr (bk_raddr),
        .bk_rdata (bk_rdata),
        .bk_wreq  (bk_wreq),
        .bk_waddr (bk_waddr),
        .bk_wdata (bk_wdata),
        .bk_wack  (bk_wack)
    );

    // ---------------- backing memory ----------------
    function automatic logic [DW-1:0] init_word(input logic [AW-1:0] a);
        return 32'h0000_1234 + (DW'(a) - 32'd5) * 32'h0101_0001;
    endfunction

    logic [DW-1:0]     bk_mem [2**AW];
    logic [2**AW-1:0]  bk_written = '0;

    assign bk_rdata = bk_written[bk_raddr] ? bk_mem[bk_raddr] : init_word(bk_raddr);

    always @(posedge clk) begin
        if (bk_wreq && bk_wack) begin
            bk_mem[bk_waddr]     <= bk_wdata;
            bk_written[bk_waddr] <= 1'b1;
        end
    end

    // ---------------- reference model + scoreboard ----------------
    typedef struct {
        logic [DW-1:0] q;
        logic          stall;
        logic          wreq;
        logic [AW-1:0] waddr;
        logic [DW-1:0] wdata;
    } cyc_exp_t;

    cyc_exp_t      exp_q[$];
    sb_entry_t     exp_wr_q[$];
    sb_entry_t     model_q[$];
    logic [DW-1:0] model_mem [2**AW];

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // ---------------- driver ----------------
    task automatic cycle(input logic cen, input logic wen, input logic oen,
                         input logic [AW-1:0] a, input logic [DW-1:0] d, input logic wack);
        cyc_exp_t  e;
        sb_entry_t hd;
        logic      is_store, is_load, do_push, do_pop;
        @(posedge clk);
        #1;
        CEN = cen; WEN = wen; OEN = oen; A = a; D = d; bk_wack = wack;
        is_store = !cen && !wen;
        is_load  = !cen && wen && !oen;
        e.stall  = is_store && (model_q.size() == DEPTH);
        e.wreq   = (model_q.size() != 0);
        e.waddr  = e.wreq ? model_q[0].addr : '0;
        e.wdata  = e.wreq ? model_q[0].data : '0;
        e.q      = '0;
        if (is_load) begin
            e.q = model_mem[a];
            foreach (model_q[k]) if (model_q[k].addr == a) e.q = model_q[k].data;
        end
        exp_q.push_back(e);
        do_pop  = e.wreq && wack;
        do_push = is_store && !e.stall;
        if (do_pop) begin
            hd = model_q.pop_front();
            model_mem[hd.addr] = hd.data;
        end
        if (do_push) begin
            model_q.push_back(sb_entry_t'{addr: a, data: d});
            exp_wr_q.push_back(sb_entry_t'{addr: a, data: d});
        end
    endtask

    task automatic store(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic wack);
        cycle(1'b0, 1'b0, 1'b1, a, d, wack);
    endtask

    task automatic load(input logic [AW-1:0] a, input logic wack);
        cycle(1'b0, 1'b1, 1'b0, a, '0, wack);
    endtask

    task automatic idle(input logic wack);
        cycle(1'b1, 1'b1, 1'b1, '0, '0, wack);
    endtask

    task automatic drain();
        int guard = 0;
        while (model_q.size() > 0 && guard < 64) begin
            idle(1'b1);
            guard++;
        end
        idle(1'b0);
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin : monitor
        cyc_exp_t  e;
        sb_entry_t w;
        if (rst_n && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("Q", Q, e.q);
            check("stall", DW'(stall), DW'(e.stall));
            check("bk_wreq", DW'(bk_wreq), DW'(e.wreq));
            if (e.wreq) begin
                check("bk_waddr", DW'(bk_waddr), DW'(e.waddr));
                check("bk_wdata", bk_wdata, e.wdata);
            end
        end
        if (rst_n && bk_wreq && bk_wack) begin
            if (exp_wr_q.size() == 0) begin
                check("unexpected_write", DW'(bk_waddr), '1);
            end else begin
                w = exp_wr_q.pop_front();
                check("write_addr", DW'(bk_waddr), DW'(w.addr));
                check("write_data", bk_wdata, w.data);
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int op;
        rst_n = 1'b0;
        CEN = 1'b1; WEN = 1'b1; OEN = 1'b1; A = '0; D = '0; bk_wack = 1'b0;
        for (int i = 0; i < 2**AW; i++) model_mem[i] = init_word(AW'(i));
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk); #1;
        check("reset_Q", Q, '0);
        check("reset_stall", DW'(stall), '0);
        check("reset_wreq", DW'(bk_wreq), '0);
        check("reset_waddr", DW'(bk_waddr), '0);
        check("reset_wdata", bk_wdata, '0);

        // empty-buffer load goes to backing memory
        load(7'd5, 1'b0);
        // store then forward next cycle
        store(7'd3, 32'hAAAA, 1'b0);
        load(7'd3, 1'b0);
        // duplicate addresses: youngest forwards, drain in program order
        store(7'd7, 32'd1, 1'b0);
        store(7'd7, 32'd2, 1'b0);
        load(7'd7, 1'b0);
        drain();
        load(7'd7, 1'b0);

        // fill, stall on fifth, pop+refused push on same edge, then re-present
        for (int i = 0; i < 5; i++) store(AW'(10 + i), DW'(32'h100 + i), 1'b0);
        store(7'd14, 32'h104, 1'b1);
        store(7'd14, 32'h104, 1'b0);
        load(7'd14, 1'b0);
        load(7'd10, 1'b0);
        drain();

        // reset mid-drain with three entries pending
        store(7'd20, 32'hBEEF0, 1'b0);
        store(7'd21, 32'hBEEF1, 1'b0);
        store(7'd22, 32'hBEEF2, 1'b0);
        idle(1'b0);
        @(negedge clk); #2;
        rst_n = 1'b0;
        #1;
        check("midreset_wreq", DW'(bk_wreq), '0);
        check("midreset_waddr", DW'(bk_waddr), '0);
        model_q.delete();
        exp_wr_q.delete();
        @(negedge clk); #2;
        rst_n = 1'b1;
        load(7'd21, 1'b0);
        load(7'd20, 1'b0);

        // randomized traffic over a small address window
        for (int n = 0; n < 400; n++) begin
            op = $urandom_range(0, 9);
            if (op <= 3)      store(AW'($urandom_range(0, 7)), $urandom, $urandom_range(0, 2) == 0);
            else if (op <= 7) load(AW'($urandom_range(0, 7)), $urandom_range(0, 2) == 0);
            else if (op == 8) cycle(1'b0, 1'b1, 1'b1, AW'($urandom_range(0, 7)), '0, $urandom_range(0, 1) == 0);
            else              cycle(1'b1, 1'($urandom_range(0, 1)), 1'b0, AW'($urandom_range(0, 7)),
                                    $urandom, $urandom_range(0, 1) == 0);
        end
        drain();
        for (int i = 0; i < 8; i++) load(AW'(i), 1'b0);
        idle(1'b0);
        @(negedge clk); #1;
        check("drain_empty", DW'(exp_wr_q.size()), '0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
